// File: rtl/idli_ibuf_m.sv
// Instruction fetch buffer: assembles slice-serial encodings into words and
// queues up to DEPTH of them, each tagged with an immediate hint, for decode.
module idli_ibuf_m #(
  parameter  int unsigned SLICE_W = 4,
  parameter  int unsigned WORD_W  = 16,
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned SLICES  = WORD_W / SLICE_W,
  localparam int unsigned CTR_W   = $clog2(SLICES),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               i_ib_gck,
  input  logic               i_ib_rst_n,
  input  logic [CTR_W-1:0]   i_ib_ctr,
  input  logic [SLICE_W-1:0] i_ib_slice,
  input  logic               i_ib_slice_vld,
  input  logic               i_ib_flush,
  input  logic               i_ib_pop,
  output logic               o_ib_rdy,
  output logic               o_ib_vld,
  output logic [WORD_W-1:0]  o_ib_enc,
  output logic               o_ib_imm,
  output logic [CNT_W-1:0]   o_ib_cnt,
  output logic               o_ib_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if ((SLICE_W == 0) || (WORD_W % SLICE_W != 0) || (SLICES < 2) ||
      ((SLICES & (SLICES - 1)) != 0)) begin : g_bad_slices
    $error("idli_ibuf_m: WORD_W/SLICE_W must be an integral power of two >= 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("idli_ibuf_m: DEPTH must be a power of two >= 2");
  end

  logic [WORD_W-1:0]         mem_q [DEPTH];
  logic [DEPTH-1:0]          imm_mem_q;
  logic [WORD_W-SLICE_W-1:0] asm_q;

  logic             word_ok_q, word_ok_d;
  logic             imm_pend_q, imm_pend_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic              ctr_first, ctr_last, complete, pop_acc, push;
  logic [WORD_W-1:0] full_word;

  always_comb begin
    ctr_first = (i_ib_ctr == '0);
    ctr_last  = (i_ib_ctr == CTR_W'(SLICES - 1));
    // Last slice is merged live rather than registered.
    full_word = {asm_q, i_ib_slice};
    complete  = !i_ib_flush && i_ib_slice_vld && ctr_last && word_ok_q;
    pop_acc   = !i_ib_flush && i_ib_pop && (cnt_q != '0);
    push      = complete && ((cnt_q != CNT_W'(DEPTH)) || pop_acc);

    word_ok_d  = word_ok_q;
    imm_pend_d = imm_pend_q;
    ovf_d      = ovf_q | (complete & ~push);
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (!i_ib_slice_vld)  word_ok_d = 1'b0;
    else if (ctr_first)   word_ok_d = 1'b1;

    if (push) begin
      wptr_d     = wptr_q + PTR_W'(1);
      imm_pend_d = !imm_pend_q && (&i_ib_slice);
    end
    if (pop_acc) rptr_d = rptr_q + PTR_W'(1);

    case ({push, pop_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (i_ib_flush) begin
      word_ok_d  = 1'b0;
      imm_pend_d = 1'b0;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end
  end

  always_ff @(posedge i_ib_gck or negedge i_ib_rst_n) begin
    if (!i_ib_rst_n) begin
      word_ok_q  <= 1'b0;
      imm_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      word_ok_q  <= word_ok_d;
      imm_pend_q <= imm_pend_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Slice assembly and FIFO storage carry no reset; validity lives in the counters.
  always_ff @(posedge i_ib_gck) begin
    if (i_ib_slice_vld) begin
      for (int unsigned k = 0; k < SLICES - 1; k++) begin
        if (i_ib_ctr == CTR_W'(k)) asm_q[(SLICES-2-k)*SLICE_W +: SLICE_W] <= i_ib_slice;
      end
    end
    if (push) begin
      mem_q[wptr_q]     <= full_word;
      imm_mem_q[wptr_q] <= imm_pend_q;
    end
  end

  always_comb begin
    o_ib_vld = (cnt_q != '0);
    o_ib_rdy = (cnt_q != CNT_W'(DEPTH));
    o_ib_cnt = cnt_q;
    o_ib_ovf = ovf_q;
    o_ib_enc = o_ib_vld ? mem_q[rptr_q] : '0;
    o_ib_imm = o_ib_vld && imm_mem_q[rptr_q];
  end

endmodule

// File: tb/tb_idli_ibuf_m.sv
// Directed self-checking bench for idli_ibuf_m at default parameters.
module tb_idli_ibuf_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ctr = 2'd0;
  logic [3:0]  slice = '0;
  logic        slice_vld = 1'b0;
  logic        flush = 1'b0;
  logic        pop = 1'b0;
  logic        rdy, vld, imm, ovf;
  logic [15:0] enc;
  logic [1:0]  cnt;

  int tests = 0;
  int fails = 0;

  idli_ibuf_m #(.SLICE_W(4), .WORD_W(16), .DEPTH(2)) dut (
    .i_ib_gck(clk), .i_ib_rst_n(rst_n), .i_ib_ctr(ctr), .i_ib_slice(slice),
    .i_ib_slice_vld(slice_vld), .i_ib_flush(flush), .i_ib_pop(pop),
    .o_ib_rdy(rdy), .o_ib_vld(vld), .o_ib_enc(enc), .o_ib_imm(imm),
    .o_ib_cnt(cnt), .o_ib_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the edge, ctr advances afterwards.
  task automatic cyc(input logic v, input logic [3:0] s, input logic p, input logic f);
    slice_vld = v; slice = s; pop = p; flush = f;
    @(posedge clk); #1;
    ctr = ctr + 2'd1;
    slice_vld = 1'b0; slice = '0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic align();
    while (ctr != 2'd0) cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic word(input logic [15:0] w, input logic pop_last);
    align();
    for (int k = 0; k < 4; k++) cyc(1'b1, w[15-4*k -: 4], (k == 3) && pop_last, 1'b0);
  endtask

  task automatic head(input string tag, input logic [15:0] e, input logic i);
    chk({tag, "_vld"}, 32'(vld), 32'd1);
    chk({tag, "_enc"}, 32'(enc), 32'(e));
    chk({tag, "_imm"}, 32'(imm), 32'(i));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(vld), 0); chk("rst_enc", 32'(enc), 0);
    chk("rst_imm", 32'(imm), 0); chk("rst_rdy", 32'(rdy), 1);
    chk("rst_cnt", 32'(cnt), 0); chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    // Basic assembly
    word(16'hA123, 1'b0);
    head("basic", 16'hA123, 1'b0);
    chk("basic_cnt", 32'(cnt), 1); chk("basic_rdy", 32'(rdy), 1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("pop_vld", 32'(vld), 0); chk("pop_enc", 32'(enc), 0); chk("pop_cnt", 32'(cnt), 0);

    // Immediate tagging
    word(16'h123F, 1'b0); head("tag0", 16'h123F, 1'b0); cyc(1'b0, 4'h0, 1'b1, 1'b0);
    word(16'hBEEF, 1'b0); head("tag1", 16'hBEEF, 1'b1); cyc(1'b0, 4'h0, 1'b1, 1'b0);
    word(16'h00FF, 1'b0); head("tag2", 16'h00FF, 1'b0); cyc(1'b0, 4'h0, 1'b1, 1'b0);
    word(16'h4561, 1'b0); head("tag3", 16'h4561, 1'b1); cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("tag_empty", 32'(cnt), 0);

    // Overflow
    word(16'h1111, 1'b0);
    word(16'h2222, 1'b0);
    chk("full_cnt", 32'(cnt), 2); chk("full_rdy", 32'(rdy), 0); chk("full_ovf", 32'(ovf), 0);
    word(16'h3333, 1'b0);
    chk("drop_ovf", 32'(ovf), 1); chk("drop_cnt", 32'(cnt), 2);
    head("drop_head", 16'h1111, 1'b0);
    word(16'h4444, 1'b1);
    chk("pp_cnt", 32'(cnt), 2);
    head("pp_head0", 16'h2222, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    head("pp_head1", 16'h4444, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("pp_empty", 32'(cnt), 0);

    // Gap abandon
    align();
    cyc(1'b1, 4'h5, 1'b0, 1'b0); cyc(1'b1, 4'h6, 1'b0, 1'b0);
    cyc(1'b0, 4'h7, 1'b0, 1'b0); cyc(1'b1, 4'h8, 1'b0, 1'b0);
    chk("gap_cnt", 32'(cnt), 0); chk("gap_vld", 32'(vld), 0);
    word(16'h5678, 1'b0);
    chk("gap_next_cnt", 32'(cnt), 1); head("gap_next", 16'h5678, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);

    // Flush priority: full, imm pending, last slice + pop + flush together
    word(16'hAAAA, 1'b0);
    word(16'hBBBF, 1'b0);
    chk("fl_pre_cnt", 32'(cnt), 2);
    align();
    cyc(1'b1, 4'hC, 1'b0, 1'b0); cyc(1'b1, 4'hC, 1'b0, 1'b0); cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b1, 1'b1);
    chk("fl_cnt", 32'(cnt), 0); chk("fl_vld", 32'(vld), 0);
    chk("fl_rdy", 32'(rdy), 1); chk("fl_ovf", 32'(ovf), 1);
    word(16'hDDDD, 1'b0);
    head("fl_next", 16'hDDDD, 1'b0);
    chk("fl_next_cnt", 32'(cnt), 1);

    // Async reset mid-period at ctr==1
    align();
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(vld), 0); chk("ar_enc", 32'(enc), 0); chk("ar_imm", 32'(imm), 0);
    chk("ar_rdy", 32'(rdy), 1); chk("ar_cnt", 32'(cnt), 0); chk("ar_ovf", 32'(ovf), 0);
    @(posedge clk); #1;
    ctr = ctr + 2'd1;
    rst_n = 1'b1;
    cyc(1'b1, 4'h7, 1'b0, 1'b0); cyc(1'b1, 4'h7, 1'b0, 1'b0);
    chk("ar_partial_cnt", 32'(cnt), 0);
    word(16'hCAFE, 1'b0);
    head("ar_next", 16'hCAFE, 1'b0);
    chk("ar_next_cnt", 32'(cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
